// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver: majority-voted bit sampling, optional parity,
// one or two stop bits, frame/parity error flags and line-break detection.
module uart_rx_cfg #(
  parameter int CLOCK_FREQ = 38400000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 soft_reset,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK_WAIT
  } state_t;

  state_t                 state;
  logic [1:0]             sync;
  logic                   rx_prev;
  logic [TW-1:0]          tick_cnt;
  logic [SW-1:0]          samp_cnt;
  logic [3:0]             bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   samp_a;
  logic                   samp_b;
  logic                   stop_zero_seen;
  logic                   stop_one_seen;

  logic rx_s;
  logic tick;
  logic vote_now;
  logic bit_end;
  logic vote;
  logic par_calc;
  logic frame_is_break;

  assign rx_s     = sync[1];
  assign tick     = (tick_cnt == TICK_LAST);
  assign vote_now = tick && (samp_cnt == SAMP_C);
  assign bit_end  = tick && (samp_cnt == SAMP_LAST);
  assign vote     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  // Odd parity expects payload^bit == 1, even expects 0; par_calc is 1 on a mismatch.
  assign par_calc = (PARITY == 1) ? ~(^shreg ^ par_bit) :
                    (PARITY == 2) ?  (^shreg ^ par_bit) : 1'b0;

  assign frame_is_break = (shreg == '0) && ((PARITY == 0) || !par_bit) &&
                          !stop_one_seen && !vote;

  // Synchroniser idles high so reset never fabricates a falling edge; soft_reset leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= sync[1];
    end
  end

  // NOTE: all state here is written with non-blocking assignments, so later
  // assignments in the case arms cleanly override the default counter advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      tick_cnt       <= '0;
      samp_cnt       <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      par_bit        <= 1'b0;
      samp_a         <= 1'b1;
      samp_b         <= 1'b1;
      stop_zero_seen <= 1'b0;
      stop_one_seen  <= 1'b0;
      data           <= '0;
      valid          <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      break_det      <= 1'b0;
    end else if (soft_reset) begin
      state          <= ST_IDLE;
      tick_cnt       <= '0;
      samp_cnt       <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      par_bit        <= 1'b0;
      stop_zero_seen <= 1'b0;
      stop_one_seen  <= 1'b0;
      data           <= '0;
      valid          <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      break_det      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      break_det <= 1'b0;

      if (state != ST_IDLE) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
        if (tick && samp_cnt == SAMP_A) samp_a <= rx_s;
        if (tick && samp_cnt == SAMP_B) samp_b <= rx_s;
      end

      case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_s) begin
            state          <= ST_START;
            tick_cnt       <= '0;
            samp_cnt       <= '0;
            bit_idx        <= '0;
            stop_zero_seen <= 1'b0;
            stop_one_seen  <= 1'b0;
          end
        end

        ST_START: begin
          if (vote_now && vote) state <= ST_IDLE;
          else if (bit_end)     state <= ST_DATA;
        end

        ST_DATA: begin
          if (vote_now) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (vote_now) par_bit <= vote;
          if (bit_end)  state   <= ST_STOP;
        end

        ST_STOP: begin
          if (vote_now && bit_idx == STOP_LAST) begin
            if (frame_is_break) begin
              break_det <= 1'b1;
              state     <= ST_BREAK_WAIT;
              tick_cnt  <= '0;
              samp_cnt  <= '0;
            end else begin
              valid      <= 1'b1;
              data       <= shreg;
              parity_err <= par_calc;
              frame_err  <= stop_zero_seen | !vote;
              state      <= ST_IDLE;
            end
          end else begin
            if (vote_now) begin
              stop_zero_seen <= stop_zero_seen | !vote;
              stop_one_seen  <= stop_one_seen  |  vote;
            end
            if (bit_end) bit_idx <= bit_idx + 1'b1;
          end
        end

        ST_BREAK_WAIT: begin
          // Any low sample restarts the one-bit high-time measurement.
          if (!rx_s) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
          end else if (bit_end) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
